// File: rtl/div_int8_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// div0 exists only when DIV_ZERO_FLAG_EN is defined.
interface div_int8_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
`ifdef DIV_ZERO_FLAG_EN
    logic             div0;
`endif

    modport master (
        output in_valid, a, b, out_ready,
`ifdef DIV_ZERO_FLAG_EN
        input  div0,
`endif
        input  in_ready, out_valid, q, r
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef DIV_ZERO_FLAG_EN
        output div0,
`endif
        output in_ready, out_valid, q, r
    );
endinterface

// File: rtl/div_int8_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Optional divide-by-zero flag output enabled by `define DIV_ZERO_FLAG_EN.
module adder_nbit #(
    parameter int N         = 9,
    parameter int IMPL_TYPE = 0
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    generate
        if (IMPL_TYPE == 0) begin : g_behav
            assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
        end else begin : g_ripple
            logic [N:0] w_c;
            assign w_c[0] = i_cin;
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
                assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
            end
            assign o_cout = w_c[N];
        end
    endgenerate
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for operands
// BUSY  | one shift-subtract iteration per clock
// DONE  | out_valid=1, result held until out_ready
module div_int8_seq #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    div_int8_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_cout;
    logic             w_fits;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rem_next;

    // Partial remainder is WIDTH+1 bits wide so the borrow never aliases into the value.
    assign w_rem_shift = {r_rem, r_q[WIDTH-1]};

    adder_nbit #(.N(WIDTH+1), .IMPL_TYPE(IMPL_TYPE)) u_sub (
        .i_a    (w_rem_shift),
        .i_b    (~{1'b0, r_div}),
        .i_cin  (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_cout)
    );

    // Carry-out and the sign of the difference agree; both are consumed.
    assign w_fits     = w_cout & ~w_diff[WIDTH];
    assign w_q_next   = {r_q[WIDTH-2:0], w_fits};
    assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.q         = r_q_out;
    assign bus.r         = r_r_out;

`ifdef DIV_ZERO_FLAG_EN
    logic r_div0;
    assign bus.div0 = r_div0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div0 <= 1'b0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_div0 <= (bus.b == '0);
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q_out     <= '0;
            r_r_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_q        <= bus.a;
                        r_div      <= bus.b;
                        r_rem      <= '0;
                        r_cnt      <= CW'(WIDTH - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_q_out     <= w_q_next;
                        r_r_out     <= w_rem_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_int8_seq.sv
// Directed bench for div_int8_seq: latency, edge operands, backpressure, mid-op reset.
// Also checks the div0 flag when built with DIV_ZERO_FLAG_EN.
module tb_div_int8_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    div_int8_seq_if #(.WIDTH(W)) bus ();

    div_int8_seq #(.WIDTH(W), .IMPL_TYPE(0)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input int hold);
        int n;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 50) begin tick(); n++; end
        chk({tag, "_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        chk({tag, "_latency"}, n, W);
        repeat (hold) tick();
        chk({tag, "_q"}, {24'd0, bus.q}, {24'd0, eq});
        chk({tag, "_r"}, {24'd0, bus.r}, {24'd0, er});
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, "_div0"}, {31'd0, bus.div0}, {31'd0, (b == 8'd0)});
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_q_kept"}, {24'd0, bus.q}, {24'd0, eq});
    endtask

    initial begin
        logic [7:0] ra, rb, rq, rr;
        int         n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst           = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_q", {24'd0, bus.q}, 32'd0);
        chk("rst_r", {24'd0, bus.r}, 32'd0);

        // T1..T3: basic and edge operands
        run_op("t1_200_7",  8'd200, 8'd7, 8'd28,  8'd4,  0);
        run_op("t2_5_9",    8'd5,   8'd9, 8'd0,   8'd5,  0);
        run_op("t2_255_1",  8'd255, 8'd1, 8'd255, 8'd0,  1);
        run_op("t2_0_3",    8'd0,   8'd3, 8'd0,   8'd0,  0);
        run_op("t3_37_0",   8'd37,  8'd0, 8'd255, 8'd37, 0);
        run_op("t3_9_3",    8'd9,   8'd3, 8'd3,   8'd0,  0);

        // T4: backpressure with ignored in_valid
        bus.a = 8'd100; bus.b = 8'd10; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.a = 8'd7; bus.b = 8'd2;
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        chk("t4_latency", n, W);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t4_hold_q", {24'd0, bus.q}, 32'd10);
            chk("t4_hold_r", {24'd0, bus.r}, 32'd0);
            chk("t4_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("t4_no_dup", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_q_kept", {24'd0, bus.q}, 32'd10);
        bus.out_ready = 1'b0;

        // T5: reset during iteration 3
        bus.a = 8'd250; bus.b = 8'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_q", {24'd0, bus.q}, 32'd0);
        chk("t5_r", {24'd0, bus.r}, 32'd0);
        repeat (12) begin
            tick();
            chk("t5_no_output", {31'd0, bus.out_valid}, 32'd0);
        end
        run_op("t5_250_3", 8'd250, 8'd3, 8'd83, 8'd1, 0);

        // Short random sweep with divisor zero mixed in
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (rb == 8'd0) begin rq = 8'hFF; rr = ra; end
            else begin rq = ra / rb; rr = ra % rb; end
            run_op("rand", ra, rb, rq, rr, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
